gpr_file_mp: RTL and testbench
==============================

Name: gpr_file_mp

Overview:
Parametrised multi-port general-purpose register file. It is the next generation of the core GPR block.
- Configurable number of read ports and write ports.
- Optional hard-wired zero register.
- Optional same-cycle write-to-read bypass.
- One-cycle delayed read outputs for the ALU stage, with stall hold.
- Sequential clear engine that zeroes the array on request.

Sits between decode (read addresses), writeback (write ports) and the ALU input registers.

Parameters:
- DATA_WIDTH, 32, width of each register.
- GPR_ADDR_WIDTH, 5, address width; DEPTH = 2**GPR_ADDR_WIDTH entries.
- NUM_RD_PORTS, 2, number of independent read ports (1..4).
- NUM_WR_PORTS, 1, number of independent write ports (1..2).
- BYPASS_EN, 1, 1 = a same-cycle write is forwarded to the combinational read outputs.
- ZERO_REG_EN, 1, 1 = entry 0 always reads 0 and writes to it are discarded.

Ports:
- reg_clk, in, 1: single clock, all logic on the rising edge.
- reg_rst, in, 1: asynchronous, active-high reset.
- stall_pipeline, in, 1: hold the delayed read outputs.
- clr_req, in, 1: single-cycle pulse that starts a sequential clear.
- clr_busy, out, 1: high while the clear engine runs.
- wr_en, in, NUM_WR_PORTS: per-port write enable.
- wr_addr, in, NUM_WR_PORTS*GPR_ADDR_WIDTH: packed write addresses, port i at [i*AW +: AW].
- wr_data, in, NUM_WR_PORTS*DATA_WIDTH: packed write data.
- rd_addr, in, NUM_RD_PORTS*GPR_ADDR_WIDTH: packed read addresses.
- rd_data_r, out, NUM_RD_PORTS*DATA_WIDTH: combinational read data, same cycle.
- rd_data, out, NUM_RD_PORTS*DATA_WIDTH: registered read data, one cycle delayed, for the ALU.

Behaviour:
- Reset (reg_rst=1, async): all DEPTH entries = 0, rd_data = 0, clr_busy = 0, FSM = IDLE, clear counter = 0. Takes effect immediately, without a clock edge.
- Write, FSM=IDLE:
  - On posedge, entry[wr_addr[i]] <= wr_data[i] for each i with wr_en[i]=1.
  - With ZERO_REG_EN=1, writes to address 0 are dropped.
  - Same address on several ports in one cycle: the highest port index wins.
- Combinational read, per port j:
  - ZERO_REG_EN=1 and rd_addr[j]=0 -> 0.
  - Else if BYPASS_EN=1 and any enabled write port matches rd_addr[j] -> wr_data of the highest-index matching port. Zero-register suppression still applies to address 0.
  - Else -> entry[rd_addr[j]].
  - BYPASS_EN=0 -> the stored value is returned; new data becomes visible the cycle after the write edge.
- Delayed read:
  - On posedge, rd_data <= rd_data_r unless stall_pipeline=1, in which case rd_data holds.
  - Latency is 1 cycle from rd_addr to rd_data.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1; the counter loads 0.
  - In CLEAR, each posedge sets entry[counter] <= 0 and counter <= counter+1.
  - At counter = DEPTH-1, that entry is zeroed and the FSM returns to IDLE.
  - A clear takes exactly DEPTH cycles; clr_busy=1 throughout CLEAR.
  - clr_req during CLEAR is ignored, with no restart.
  - wr_en is ignored during CLEAR; the writes are lost and the issuer must wait for clr_busy=0.
  - rd_data_r is forced to 0 during CLEAR.
  - rd_data continues to follow the stall rule, so it captures 0s.
  - Reset mid-clear -> IDLE, array zero.
- Widths: no arithmetic beyond the counter. The counter is GPR_ADDR_WIDTH bits wide and its terminal compare is against DEPTH-1, so it never wraps.

Decomposition:
- Shared package gpr_pkg holds:
  - the clr_state_e typedef (IDLE, CLEAR);
  - localparam helpers for DEPTH;
  - the default DATA_WIDTH/GPR_ADDR_WIDTH constants.
- One sub-module, gpr_rd_port, is instantiated NUM_RD_PORTS times in a generate loop. It owns the zero-register check, the bypass priority mux and the stall-held output register.
- The array, write logic and clear FSM stay in the top level.

Test Plan:
1. Reset then read: assert reg_rst mid-cycle with no clock -> rd_data = 0 immediately; every address then reads 0 on both ports.
2. Write and read:
   - Write 0xDEADBEEF to x5.
   - Next cycle, rd_addr0=5 -> rd_data_r=0xDEADBEEF that cycle, rd_data=0xDEADBEEF one cycle later.
   - Write 0x1234 to x0, then read x0 -> 0.
3. Bypass: with BYPASS_EN=1, write x7=0xA5A5A5A5 while rd_addr1=7 in the same cycle -> rd_data_r1=0xA5A5A5A5 in that cycle. With BYPASS_EN=0, the same stimulus gives the old x7 value.
4. Write-port conflict: NUM_WR_PORTS=2, both ports write x3 (0x11 on port 0, 0x22 on port 1) -> x3=0x22 and the bypass shows 0x22.
5. Stall: rd_data=0x55, assert stall_pipeline for 3 cycles while rd_addr changes to a register holding 0x66 -> rd_data stays 0x55 and becomes 0x66 one cycle after the stall drops.
6. Clear:
   - Fill x1..x31 with nonzero values, then pulse clr_req -> clr_busy high for exactly 32 cycles, and rd_data_r=0 throughout.
   - A write to x9 during the clear is dropped; all entries read 0 afterwards.
   - Repeat with reg_rst asserted at clear cycle 10 -> clr_busy drops immediately and all entries read 0.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared types and sizing helpers for the multi-port GPR file.
package gpr_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_GPR_ADDR_WIDTH = 5;
  localparam int DEFAULT_DEPTH          = 2 ** DEFAULT_GPR_ADDR_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int gpr_depth(input int addr_width);
    return 2 ** addr_width;
  endfunction

endpackage

// File: rtl/gpr_rd_port.sv
// One read port: zero-register check, write bypass priority mux and the
// stall-held registered output feeding the ALU stage.
module gpr_rd_port
  import gpr_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int GPR_ADDR_WIDTH = DEFAULT_GPR_ADDR_WIDTH,
  parameter int NUM_WR_PORTS   = 1,
  parameter int BYPASS_EN      = 1,
  parameter int ZERO_REG_EN    = 1
) (
  input  logic                                 reg_clk,
  input  logic                                 reg_rst,
  input  logic                                 stall_pipeline,
  input  logic                                 clr_active,
  input  logic [GPR_ADDR_WIDTH-1:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0]                stored_data,
  input  logic [NUM_WR_PORTS-1:0]              wr_en,
  input  logic [NUM_WR_PORTS*GPR_ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]                rd_data_r,
  output logic [DATA_WIDTH-1:0]                rd_data
);

  logic [DATA_WIDTH-1:0] fwd_data;

  generate
    if (BYPASS_EN != 0) begin : g_bypass
      // Later ports overwrite earlier matches, so the highest index wins.
      always_comb begin
        fwd_data = stored_data;
        for (int i = 0; i < NUM_WR_PORTS; i++) begin
          if (wr_en[i] && (wr_addr[i*GPR_ADDR_WIDTH +: GPR_ADDR_WIDTH] == rd_addr)) begin
            fwd_data = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end else begin : g_no_bypass
      logic unused_wr_bus;
      assign unused_wr_bus = ^{wr_en, wr_addr, wr_data};
      assign fwd_data      = stored_data;
    end
  endgenerate

  always_comb begin
    rd_data_r = fwd_data;
    if (clr_active || ((ZERO_REG_EN != 0) && (rd_addr == '0))) begin
      rd_data_r = '0;
    end
  end

  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      rd_data <= '0;
    end else if (!stall_pipeline) begin
      rd_data <= rd_data_r;
    end
  end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port general-purpose register file with optional zero register,
// write bypass, delayed ALU read outputs and a sequential clear engine.
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int GPR_ADDR_WIDTH = DEFAULT_GPR_ADDR_WIDTH,
  parameter int NUM_RD_PORTS   = 2,
  parameter int NUM_WR_PORTS   = 1,
  parameter int BYPASS_EN      = 1,
  parameter int ZERO_REG_EN    = 1
) (
  input  logic                                   reg_clk,
  input  logic                                   reg_rst,
  input  logic                                   stall_pipeline,
  input  logic                                   clr_req,
  output logic                                   clr_busy,
  input  logic [NUM_WR_PORTS-1:0]                wr_en,
  input  logic [NUM_WR_PORTS*GPR_ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0]     wr_data,
  input  logic [NUM_RD_PORTS*GPR_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]     rd_data_r,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]     rd_data
);

  localparam int DEPTH = gpr_depth(GPR_ADDR_WIDTH);
  localparam logic [GPR_ADDR_WIDTH-1:0] LAST_ENTRY = GPR_ADDR_WIDTH'(DEPTH - 1);

  clr_state_e                state;
  clr_state_e                next_state;
  logic [GPR_ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (clr_req) next_state = CLEAR;
      CLEAR:   if (clr_cnt == LAST_ENTRY) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      clr_cnt <= '0;
    end else if (state == IDLE) begin
      if (clr_req) clr_cnt <= '0;
    end else begin
      clr_cnt <= (clr_cnt == LAST_ENTRY) ? '0 : clr_cnt + 1'b1;
    end
  end

  // Writes are lost while clearing; among live ports the highest index lands last.
  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR_PORTS; i++) begin
        if (wr_en[i] &&
            !((ZERO_REG_EN != 0) && (wr_addr[i*GPR_ADDR_WIDTH +: GPR_ADDR_WIDTH] == '0))) begin
          mem[wr_addr[i*GPR_ADDR_WIDTH +: GPR_ADDR_WIDTH]] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign clr_busy = (state == CLEAR);

  generate
    for (genvar j = 0; j < NUM_RD_PORTS; j++) begin : g_rd
      logic [DATA_WIDTH-1:0] stored_data;
      assign stored_data = mem[rd_addr[j*GPR_ADDR_WIDTH +: GPR_ADDR_WIDTH]];

      gpr_rd_port #(
        .DATA_WIDTH     (DATA_WIDTH),
        .GPR_ADDR_WIDTH (GPR_ADDR_WIDTH),
        .NUM_WR_PORTS   (NUM_WR_PORTS),
        .BYPASS_EN      (BYPASS_EN),
        .ZERO_REG_EN    (ZERO_REG_EN)
      ) u_rd_port (
        .reg_clk        (reg_clk),
        .reg_rst        (reg_rst),
        .stall_pipeline (stall_pipeline),
        .clr_active     (clr_busy),
        .rd_addr        (rd_addr[j*GPR_ADDR_WIDTH +: GPR_ADDR_WIDTH]),
        .stored_data    (stored_data),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_data_r      (rd_data_r[j*DATA_WIDTH +: DATA_WIDTH]),
        .rd_data        (rd_data[j*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed bench: a two-write-port bypassing instance and a single-write-port
// non-bypassing instance driven from shared stimulus.
module tb_gpr_file_mp;

  logic        reg_clk = 1'b0;
  logic        reg_rst;
  logic        stall_pipeline;
  logic        clr_req;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;

  logic        clr_busy;
  logic [63:0] rd_data_r;
  logic [63:0] rd_data;
  logic        nb_clr_busy;
  logic [63:0] nb_rd_data_r;
  logic [63:0] nb_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 reg_clk = ~reg_clk;

  gpr_file_mp #(
    .DATA_WIDTH(32), .GPR_ADDR_WIDTH(5), .NUM_RD_PORTS(2),
    .NUM_WR_PORTS(2), .BYPASS_EN(1), .ZERO_REG_EN(1)
  ) u_dut (
    .reg_clk(reg_clk), .reg_rst(reg_rst), .stall_pipeline(stall_pipeline),
    .clr_req(clr_req), .clr_busy(clr_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data_r(rd_data_r), .rd_data(rd_data)
  );

  gpr_file_mp #(
    .DATA_WIDTH(32), .GPR_ADDR_WIDTH(5), .NUM_RD_PORTS(2),
    .NUM_WR_PORTS(1), .BYPASS_EN(0), .ZERO_REG_EN(1)
  ) u_nbp (
    .reg_clk(reg_clk), .reg_rst(reg_rst), .stall_pipeline(stall_pipeline),
    .clr_req(clr_req), .clr_busy(nb_clr_busy), .wr_en(wr_en[0]), .wr_addr(wr_addr[4:0]),
    .wr_data(wr_data[31:0]), .rd_addr(rd_addr), .rd_data_r(nb_rd_data_r), .rd_data(nb_rd_data)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [31:0] nb0;
    logic [31:0] nb1;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive inputs on the falling edge and let combinational outputs settle.
  task automatic applyStimulus(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic stall, input logic clr);
    @(negedge reg_clk);
    wr_en          = we;
    wr_addr        = {wa1, wa0};
    wr_data        = {wd1, wd0};
    rd_addr        = {ra1, ra0};
    stall_pipeline = stall;
    clr_req        = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge reg_clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    for (int a = 0; a < 32; a++) begin
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 1'b0, 1'b0);
      checkOutput($sformatf("%s_r0_x%0d", tag, a), rd_data_r[31:0], 32'h0);
      checkOutput($sformatf("%s_r1_x%0d", tag, 31 - a), rd_data_r[63:32], 32'h0);
      checkOutput($sformatf("%s_nb_x%0d", tag, a), nb_rd_data_r[31:0], 32'h0);
    end
  endtask

  task automatic fillArray();
    for (int i = 1; i < 32; i++) begin
      applyStimulus(2'b01, 5'(i), 32'h1000_0000 | 32'(i), 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd31, 5'd1, 1'b0, 1'b0);
    checkOutput("fill_x31", rd_data_r[31:0], 32'h1000_001F);
    checkOutput("fill_x1", rd_data_r[63:32], 32'h1000_0001);
  endtask

  initial begin
    int busy_cycles;

    vecs[0]  = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,      5'd5,  5'd7,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
    vecs[1]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,      5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[2]  = '{2'b01, 5'd0,  32'h1234,     5'd0,  32'h0,      5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,      5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[4]  = '{2'b01, 5'd7,  32'hA5A5A5A5, 5'd0,  32'h0,      5'd5,  5'd7,  32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0};
    vecs[5]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,      5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[6]  = '{2'b11, 5'd3,  32'h11,       5'd3,  32'h22,     5'd3,  5'd3,  32'h22,       32'h22,       32'h0,        32'h0};
    vecs[7]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,      5'd3,  5'd5,  32'h22,       32'hDEADBEEF, 32'h11,       32'hDEADBEEF};
    vecs[8]  = '{2'b11, 5'd10, 32'h55,       5'd11, 32'h66,     5'd10, 5'd11, 32'h55,       32'h66,       32'h0,        32'h0};
    vecs[9]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,      5'd10, 5'd11, 32'h55,       32'h66,       32'h55,       32'h0};
    vecs[10] = '{2'b11, 5'd12, 32'h77,       5'd0,  32'hFFFF,   5'd0,  5'd12, 32'h0,        32'h77,       32'h0,        32'h0};
    vecs[11] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,      5'd12, 5'd0,  32'h77,       32'h0,        32'h77,       32'h0};

    reg_rst        = 1'b1;
    stall_pipeline = 1'b0;
    clr_req        = 1'b0;
    wr_en          = '0;
    wr_addr        = '0;
    wr_data        = '0;
    rd_addr        = '0;
    repeat (2) @(posedge reg_clk);
    @(negedge reg_clk);
    reg_rst = 1'b0;
    #1;
    checkOutput("rst_rd_data0", rd_data[31:0], 32'h0);
    checkOutput("rst_rd_data1", rd_data[63:32], 32'h0);
    checkOutput("rst_clr_busy", {31'h0, clr_busy}, 32'h0);

    // Table vectors: combinational result this cycle, registered copy after the edge.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
                    vecs[i].ra0, vecs[i].ra1, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d_r0", i), rd_data_r[31:0], vecs[i].exp0);
      checkOutput($sformatf("vec%0d_r1", i), rd_data_r[63:32], vecs[i].exp1);
      checkOutput($sformatf("vec%0d_nb_r0", i), nb_rd_data_r[31:0], vecs[i].nb0);
      checkOutput($sformatf("vec%0d_nb_r1", i), nb_rd_data_r[63:32], vecs[i].nb1);
      tick();
      checkOutput($sformatf("vec%0d_d0", i), rd_data[31:0], vecs[i].exp0);
      checkOutput($sformatf("vec%0d_d1", i), rd_data[63:32], vecs[i].exp1);
      checkOutput($sformatf("vec%0d_nb_d0", i), nb_rd_data[31:0], vecs[i].nb0);
    end

    // Stall hold: x10=0x55, x11=0x66, x12=0x77.
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 5'd12, 1'b0, 1'b0);
    tick();
    checkOutput("stall_pre_d0", rd_data[31:0], 32'h55);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd11, 5'd0, 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("stall_hold%0d_d0", c), rd_data[31:0], 32'h55);
      checkOutput($sformatf("stall_hold%0d_d1", c), rd_data[63:32], 32'h77);
    end
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd11, 5'd12, 1'b0, 1'b0);
    tick();
    checkOutput("stall_release_d0", rd_data[31:0], 32'h66);
    checkOutput("stall_release_d1", rd_data[63:32], 32'h77);

    // Asynchronous reset between edges must clear the registered outputs at once.
    #1;
    reg_rst = 1'b1;
    #1;
    checkOutput("async_rst_d0", rd_data[31:0], 32'h0);
    checkOutput("async_rst_d1", rd_data[63:32], 32'h0);
    @(negedge reg_clk);
    reg_rst = 1'b0;
    checkAllZero("after_rst");

    // Full clear with an ignored re-request and a dropped write to x9.
    fillArray();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd31, 5'd9, 1'b0, 1'b1);
    tick();
    checkOutput("clr_busy_start", {31'h0, clr_busy}, 32'h1);
    busy_cycles = 0;
    while (clr_busy && busy_cycles < 100) begin
      if (busy_cycles == 3)
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd31, 5'd9, 1'b0, 1'b1);
      else if (busy_cycles == 20)
        applyStimulus(2'b01, 5'd9, 32'h0000_0999, 5'd0, 32'h0, 5'd31, 5'd9, 1'b0, 1'b0);
      else
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd31, 5'd9, 1'b0, 1'b0);
      checkOutput($sformatf("clr_cyc%0d_r0", busy_cycles), rd_data_r[31:0], 32'h0);
      checkOutput($sformatf("clr_cyc%0d_r1", busy_cycles), rd_data_r[63:32], 32'h0);
      tick();
      checkOutput($sformatf("clr_cyc%0d_d0", busy_cycles), rd_data[31:0], 32'h0);
      busy_cycles++;
    end
    checkOutput("clr_busy_cycles", 32'(busy_cycles), 32'd32);
    checkAllZero("after_clr");

    // Reset during a clear returns to idle and leaves the array zeroed.
    fillArray();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd31, 5'd1, 1'b0, 1'b1);
    tick();
    checkOutput("clr2_busy_start", {31'h0, clr_busy}, 32'h1);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd31, 5'd1, 1'b0, 1'b0);
      tick();
    end
    checkOutput("clr2_busy_mid", {31'h0, clr_busy}, 32'h1);
    #1;
    reg_rst = 1'b1;
    #1;
    checkOutput("clr2_rst_busy", {31'h0, clr_busy}, 32'h0);
    @(negedge reg_clk);
    reg_rst = 1'b0;
    checkAllZero("after_clr_rst");
    tick();
    checkOutput("clr2_busy_stays_low", {31'h0, clr_busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
